uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ word producers.
// Optional WAIT-state abort timer enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned N       = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned RW      = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [RW-1:0]     owner,
  output logic              tx_start,
  output logic [N-1:0]      tx_data,
  input  logic              tx_ready,
  output logic              timeout_err
);

  if (RW < $clog2(NREQ) || TW < $clog2(TIMEOUT + 1)) begin : g_bad_param
    $error("uart_tx_arbiter: RW or TW too narrow for NREQ/TIMEOUT");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sub_q, sub_d;
  logic [RW-1:0]   ptr_q, ptr_d;
  logic [RW-1:0]   owner_d, pick, owner_inc;
  logic [NREQ-1:0] ack_d, done_d;
  logic [N-1:0]    tx_data_d;
  logic            busy_d, tx_start_d;
  logic            found, expire;
  int unsigned     idx;

  // First requester at or after ptr, wrapping at NREQ
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = RW'(idx);
      end
    end
  end

  assign owner_inc = (owner == RW'(NREQ - 1)) ? '0 : owner + RW'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;

  // Counts WAIT cycles; expire marks the TIMEOUT-th one
  assign expire      = (tcnt_q == TW'(TIMEOUT - 1));
  assign timeout_err = err_q;

  always_comb begin
    tcnt_d = '0;
    err_d  = err_q;
    if (state_q == WAIT) begin
      tcnt_d = tcnt_q + TW'(1);
      if (expire && !tx_ready) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    ptr_d     = ptr_q;
    owner_d   = owner;
    tx_data_d = tx_data;
    ack_d     = '0;
    done_d    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = START;
          sub_d     = 2'd0;
          owner_d   = pick;
          tx_data_d = req_data[pick*N +: N];
          ack_d     = NREQ'(1) << pick;
        end
      end
      START: begin
        sub_d = sub_q + 2'd1;
        if (sub_q == 2'd1) state_d = WAIT;
      end
      WAIT: begin
        // tx_ready wins over a simultaneous expiry
        if (tx_ready || expire) begin
          done_d  = NREQ'(1) << owner;
          ptr_d   = owner_inc;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    tx_start_d = (state_d == START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sub_q    <= 2'd0;
      ptr_q    <= '0;
      owner    <= '0;
      tx_data  <= '0;
      ack      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      ptr_q    <= ptr_d;
      owner    <= owner_d;
      tx_data  <= tx_data_d;
      ack      <= ack_d;
      done     <= done_d;
      busy     <= busy_d;
      tx_start <= tx_start_d;
    end
  end

endmodule
